// File: rtl/adder14_arbiter.sv
// adder14_arbiter
//   Round-robin arbiter that shares one 14-bit adder (start/busy/done
//   handshake) among NUM_REQ requesters. One request is picked, its operands
//   are issued to the adder, and the sum/carry is returned to the winner
//   with a one-cycle one-hot resp_valid pulse.
//
// Optional feature: define ADDER14_ARB_TIMEOUT_EN to build a WAIT-state
//   watchdog that aborts an operation after TIMEOUT cycles without add_done
//   (response with resp_err=1, resp_sum=0). Without the macro WAIT waits
//   forever and resp_err is tied to 0.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   req                   per-requester request, held until own resp_valid
//   a_in, b_in            packed operands, requester k at [14k+13:14k]
//   grant                 one-hot owner of the current operation, 0 when idle
//   resp_valid            one-hot one-cycle result pulse
//   resp_sum/carry/err    result data, valid with resp_valid
//   arb_busy              high while an operation is in ISSUE or WAIT
//   add_start/a/b         adder command side
//   add_busy/done/sum/carry  adder status/result side
//
// States
//   IDLE  | no operation; arbitrate when something is eligible and adder free
//   ISSUE | add_start pulse for the latched owner
//   WAIT  | waiting for add_done (or watchdog expiry)

module adder14_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [14*NUM_REQ-1:0]   a_in,
  input  logic [14*NUM_REQ-1:0]   b_in,
  output logic [NUM_REQ-1:0]      grant,
  output logic [NUM_REQ-1:0]      resp_valid,
  output logic [13:0]             resp_sum,
  output logic                    resp_carry,
  output logic                    resp_err,
  output logic                    arb_busy,
  output logic                    add_start,
  output logic [13:0]             add_a,
  output logic [13:0]             add_b,
  input  logic                    add_busy,
  input  logic                    add_done,
  input  logic [13:0]             add_sum,
  input  logic                    add_carry
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t               state_q;
  logic [IW-1:0]        idx_q;
  logic [IW-1:0]        ptr_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [NUM_REQ-1:0]   resp_valid_q;
  logic [13:0]          resp_sum_q;
  logic                 resp_carry_q;
  logic                 arb_busy_q;
  logic                 add_start_q;
  logic [13:0]          add_a_q;
  logic [13:0]          add_b_q;

  logic [NUM_REQ-1:0]   eligible;
  logic                 pick_found_d;
  logic [IW-1:0]        pick_idx_d;
  logic [13:0]          pick_a_d;
  logic [13:0]          pick_b_d;
  int                   scan_j;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] k);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] k);
    if (int'(k) >= NUM_REQ - 1) return '0;
    return k + IW'(1);
  endfunction

  // Round-robin pick. The scan runs from the farthest offset back to ptr so
  // the last hit, which is kept, is the first eligible index at or after ptr.
  // The requester being answered this cycle is masked so it cannot win again
  // on the strength of a req it has not yet had a chance to drop.
  always_comb begin
    eligible     = req & ~resp_valid_q;
    pick_found_d = 1'b0;
    pick_idx_d   = '0;
    pick_a_d     = '0;
    pick_b_d     = '0;
    scan_j       = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      scan_j = (int'(ptr_q) + i) % NUM_REQ;
      if (eligible[scan_j]) begin
        pick_found_d = 1'b1;
        pick_idx_d   = IW'(scan_j);
        pick_a_d     = a_in[14*scan_j +: 14];
        pick_b_d     = b_in[14*scan_j +: 14];
      end
    end
  end

`ifdef ADDER14_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] to_cnt_q;
  logic          resp_err_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      ptr_q        <= '0;
      grant_q      <= '0;
      resp_valid_q <= '0;
      resp_sum_q   <= '0;
      resp_carry_q <= 1'b0;
      arb_busy_q   <= 1'b0;
      add_start_q  <= 1'b0;
      add_a_q      <= '0;
      add_b_q      <= '0;
`ifdef ADDER14_ARB_TIMEOUT_EN
      to_cnt_q     <= '0;
      resp_err_q   <= 1'b0;
`endif
    end else begin
      resp_valid_q <= '0;
      add_start_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pick_found_d && !add_busy) begin
            idx_q       <= pick_idx_d;
            add_a_q     <= pick_a_d;
            add_b_q     <= pick_b_d;
            grant_q     <= onehot(pick_idx_d);
            add_start_q <= 1'b1;
            arb_busy_q  <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
`ifdef ADDER14_ARB_TIMEOUT_EN
          to_cnt_q <= '0;
`endif
          state_q  <= S_WAIT;
        end
        S_WAIT: begin
          if (add_done) begin
            resp_sum_q   <= add_sum;
            resp_carry_q <= add_carry;
            resp_valid_q <= onehot(idx_q);
            grant_q      <= '0;
            arb_busy_q   <= 1'b0;
            ptr_q        <= next_idx(idx_q);
            state_q      <= S_IDLE;
`ifdef ADDER14_ARB_TIMEOUT_EN
            resp_err_q   <= 1'b0;
`endif
          end
`ifdef ADDER14_ARB_TIMEOUT_EN
          // Abort: the owner still gets its pulse so it can release req.
          else if (to_cnt_q == CW'(TIMEOUT)) begin
            resp_sum_q   <= '0;
            resp_carry_q <= 1'b0;
            resp_err_q   <= 1'b1;
            resp_valid_q <= onehot(idx_q);
            grant_q      <= '0;
            arb_busy_q   <= 1'b0;
            ptr_q        <= next_idx(idx_q);
            state_q      <= S_IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + CW'(1);
          end
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef ADDER14_ARB_TIMEOUT_EN
  assign resp_err = resp_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign resp_err       = 1'b0;
`endif

  assign grant      = grant_q;
  assign resp_valid = resp_valid_q;
  assign resp_sum   = resp_sum_q;
  assign resp_carry = resp_carry_q;
  assign arb_busy   = arb_busy_q;
  assign add_start  = add_start_q;
  assign add_a      = add_a_q;
  assign add_b      = add_b_q;

endmodule
